// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master unified memory arbiter: FSM states,
// master IDs and the legal range of the access latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic MST_A = 1'b0;
  localparam logic MST_B = 1'b1;

  // The access counter is 4 bits wide, which bounds LATENCY to 1..15.
  localparam int CNT_W       = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The last-grant register starts at B so A wins
// the first tie, and it only moves when a grant is actually issued with iEn=1.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic iCLK,
  input  logic iRST,
  input  logic iReqA,
  input  logic iReqB,
  input  logic iEn,
  output logic oGntA,
  output logic oGntB
);

  logic last_q, last_d;

  always_comb begin
    oGntA = iEn && iReqA && (!iReqB || (last_q == MST_B));
    oGntB = iEn && iReqB && (!iReqA || (last_q == MST_A));
  end

  always_comb begin
    last_d = last_q;
    if (oGntA) begin
      last_d = MST_A;
    end else if (oGntB) begin
      last_d = MST_B;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      last_q <= MST_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter_multi.sv
// Shares one unified instruction/data memory port between the CPU (A) and a
// secondary master (B): grant in IDLE, drive memory for LATENCY cycles, pulse Done.
module mem_arbiter_multi
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iAReq,
  input  logic              iAWe,
  input  logic [ADDR_W-1:0] iAAddr,
  input  logic [DATA_W-1:0] iAWData,
  output logic              oAAck,
  output logic              oADone,
  output logic [DATA_W-1:0] oARData,
  input  logic              iBReq,
  input  logic              iBWe,
  input  logic [ADDR_W-1:0] iBAddr,
  input  logic [DATA_W-1:0] iBWData,
  output logic              oBAck,
  output logic              oBDone,
  output logic [DATA_W-1:0] oBRData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oMemWe,
  output logic              oMemRe,
  input  logic [DATA_W-1:0] iMemRData,
  output logic [1:0]        oDbgState
);

  // Out-of-range LATENCY values are clamped to what the 4-bit counter can hold.
  localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic idle;
  logic gnt_a, gnt_b;

  assign idle = (state_q == ST_IDLE);

  rr_arbiter_2 u_arb (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iReqA (iAReq),
    .iReqB (iBReq),
    .iEn   (idle),
    .oGntA (gnt_a),
    .oGntB (gnt_b)
  );

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_a || gnt_b) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == CNT_ONE) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Latch the winning request in IDLE; count down and capture read data in ACCESS.
  always_comb begin
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (idle && (gnt_a || gnt_b)) begin
      owner_d = gnt_b ? MST_B : MST_A;
      we_d    = gnt_b ? iBWe : iAWe;
      addr_d  = gnt_b ? iBAddr : iAAddr;
      wdata_d = gnt_b ? iBWData : iAWData;
      cnt_d   = LAT_CNT;
    end else if (state_q == ST_ACCESS) begin
      cnt_d = cnt_q - CNT_ONE;
      if ((cnt_q == CNT_ONE) && !we_q) begin
        if (owner_q == MST_A) begin
          a_rdata_d = iMemRData;
        end else begin
          b_rdata_d = iMemRData;
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q     <= '0;
      owner_q   <= MST_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // FSM outputs; the write strobe fires only on the first ACCESS cycle.
  always_comb begin
    oMemAddr  = '0;
    oMemWData = '0;
    oMemWe    = 1'b0;
    oMemRe    = 1'b0;
    oADone    = 1'b0;
    oBDone    = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        oMemAddr  = addr_q;
        oMemWData = wdata_q;
        oMemRe    = !we_q;
        oMemWe    = we_q && (cnt_q == LAT_CNT);
      end
      ST_DONE: begin
        oADone = (owner_q == MST_A);
        oBDone = (owner_q == MST_B);
      end
      default: ;
    endcase
  end

  assign oAAck     = gnt_a;
  assign oBAck     = gnt_b;
  assign oARData   = a_rdata_q;
  assign oBRData   = b_rdata_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Directed bench for mem_arbiter_multi: one instance at LATENCY=1 and one at
// LATENCY=3 share the same master/memory stimulus; each step checks one of them.
module tb_mem_arbiter_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, mem_rdata;

  logic        l1_a_ack, l1_a_done, l1_b_ack, l1_b_done, l1_mem_we, l1_mem_re;
  logic [31:0] l1_a_rdata, l1_b_rdata, l1_mem_addr, l1_mem_wdata;
  logic [1:0]  l1_state;
  logic        l3_a_ack, l3_a_done, l3_b_ack, l3_b_done, l3_mem_we, l3_mem_re;
  logic [31:0] l3_a_rdata, l3_b_rdata, l3_mem_addr, l3_mem_wdata;
  logic [1:0]  l3_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_arbiter_multi #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_l1 (
    .iCLK(clk), .iRST(rst),
    .iAReq(a_req), .iAWe(a_we), .iAAddr(a_addr), .iAWData(a_wdata),
    .oAAck(l1_a_ack), .oADone(l1_a_done), .oARData(l1_a_rdata),
    .iBReq(b_req), .iBWe(b_we), .iBAddr(b_addr), .iBWData(b_wdata),
    .oBAck(l1_b_ack), .oBDone(l1_b_done), .oBRData(l1_b_rdata),
    .oMemAddr(l1_mem_addr), .oMemWData(l1_mem_wdata), .oMemWe(l1_mem_we),
    .oMemRe(l1_mem_re), .iMemRData(mem_rdata), .oDbgState(l1_state)
  );

  mem_arbiter_multi #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_l3 (
    .iCLK(clk), .iRST(rst),
    .iAReq(a_req), .iAWe(a_we), .iAAddr(a_addr), .iAWData(a_wdata),
    .oAAck(l3_a_ack), .oADone(l3_a_done), .oARData(l3_a_rdata),
    .iBReq(b_req), .iBWe(b_we), .iBAddr(b_addr), .iBWData(b_wdata),
    .oBAck(l3_b_ack), .oBDone(l3_b_done), .oBRData(l3_b_rdata),
    .oMemAddr(l3_mem_addr), .oMemWData(l3_mem_wdata), .oMemWe(l3_mem_we),
    .oMemRe(l3_mem_re), .iMemRData(mem_rdata), .oDbgState(l3_state)
  );

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    mem_rdata = '0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      chk(tag, 64'(obs), 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // reset state
    do_reset();
    smp();
    chk("rst_l1_outs", 64'({l1_mem_re, l1_mem_we, l1_a_ack, l1_b_ack, l1_a_done, l1_b_done}), 64'd0);
    chk("rst_l1_rdata", 64'({l1_a_rdata, l1_b_rdata}), 64'd0);
    chk("rst_l3_outs", 64'({l3_mem_re, l3_mem_we, l3_a_ack, l3_b_ack, l3_a_done, l3_b_done}), 64'd0);
    chk("rst_l1_state", 64'(l1_state), 64'd0);

    // single read, LATENCY=1
    nxt();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0040_0000;
    exp_q.push_back(32'hDEAD_BEEF);
    smp();
    chk("rd1_c0_aack", 64'(l1_a_ack), 64'd1);
    chk("rd1_c0_back", 64'(l1_b_ack), 64'd0);
    nxt();
    a_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("rd1_c1_re", 64'(l1_mem_re), 64'd1);
    chk("rd1_c1_addr", 64'(l1_mem_addr), 64'h0040_0000);
    chk("rd1_c1_done", 64'(l1_a_done), 64'd0);
    nxt();
    mem_rdata = 32'h0;
    smp();
    chk("rd1_c2_done", 64'(l1_a_done), 64'd1);
    chk_rd("rd1_c2_rdata", l1_a_rdata);
    chk("rd1_c2_re", 64'(l1_mem_re), 64'd0);
    nxt();
    smp();
    chk("rd1_c3_state", 64'(l1_state), 64'd0);
    chk("rd1_c3_done", 64'(l1_a_done), 64'd0);

    // tie after reset, both held: acks alternate A, B, A, B every 3 cycles
    do_reset();
    a_req = 1'b1; a_addr = 32'h0000_1000;
    b_req = 1'b1; b_addr = 32'h0000_2000;
    for (int c = 0; c < 12; c++) begin
      smp();
      chk($sformatf("tie_c%0d_aack", c), 64'(l1_a_ack), 64'((c % 3 == 0) && ((c / 3) % 2 == 0)));
      chk($sformatf("tie_c%0d_back", c), 64'(l1_b_ack), 64'((c % 3 == 0) && ((c / 3) % 2 == 1)));
      nxt();
    end

    // B write, LATENCY=3
    do_reset();
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h1001_0000; b_wdata = 32'h1234_5678;
    mem_rdata = 32'hFFFF_0000;
    smp();
    chk("wr_c0_back", 64'(l3_b_ack), 64'd1);
    nxt();
    b_req = 1'b0; b_we = 1'b0;
    smp();
    chk("wr_c1_we", 64'(l3_mem_we), 64'd1);
    chk("wr_c1_addr", 64'(l3_mem_addr), 64'h1001_0000);
    chk("wr_c1_wdata", 64'(l3_mem_wdata), 64'h1234_5678);
    chk("wr_c1_re", 64'(l3_mem_re), 64'd0);
    for (int c = 2; c < 4; c++) begin
      nxt();
      smp();
      chk($sformatf("wr_c%0d_we", c), 64'(l3_mem_we), 64'd0);
      chk($sformatf("wr_c%0d_done", c), 64'(l3_b_done), 64'd0);
    end
    nxt();
    smp();
    chk("wr_c4_done", 64'(l3_b_done), 64'd1);
    chk("wr_c4_rdata", 64'(l3_b_rdata), 64'd0);
    nxt();
    smp();
    chk("wr_c5_done", 64'(l3_b_done), 64'd0);

    // A read LATENCY=3 with B arriving mid-access
    do_reset();
    a_req = 1'b1; a_addr = 32'h0000_0100;
    exp_q.push_back(32'hCAFE_F00D);
    smp();
    chk("rd3_c0_aack", 64'(l3_a_ack), 64'd1);
    nxt();
    a_req = 1'b0; mem_rdata = 32'h0BAD_BAD0;
    smp();
    chk("rd3_c1_re", 64'(l3_mem_re), 64'd1);
    nxt();
    b_req = 1'b1; b_addr = 32'h0000_0200;
    smp();
    chk("rd3_c2_re", 64'(l3_mem_re), 64'd1);
    chk("rd3_c2_back", 64'(l3_b_ack), 64'd0);
    nxt();
    mem_rdata = 32'hCAFE_F00D;
    smp();
    chk("rd3_c3_re", 64'(l3_mem_re), 64'd1);
    chk("rd3_c3_done", 64'(l3_a_done), 64'd0);
    nxt();
    mem_rdata = 32'h0BAD_BAD0;
    smp();
    chk("rd3_c4_done", 64'(l3_a_done), 64'd1);
    chk_rd("rd3_c4_rdata", l3_a_rdata);
    chk("rd3_c4_re", 64'(l3_mem_re), 64'd0);
    chk("rd3_c4_back", 64'(l3_b_ack), 64'd0);
    nxt();
    exp_q.push_back(32'h5A5A_5A5A);
    smp();
    chk("rd3_c5_back", 64'(l3_b_ack), 64'd1);
    nxt();
    b_req = 1'b0;
    smp();
    chk("rd3_c6_addr", 64'(l3_mem_addr), 64'h0000_0200);
    nxt();
    nxt();
    mem_rdata = 32'h5A5A_5A5A;
    nxt();
    mem_rdata = 32'h0;
    smp();
    chk("rd3_c9_bdone", 64'(l3_b_done), 64'd1);
    chk_rd("rd3_c9_brdata", l3_b_rdata);

    // reset in the middle of a LATENCY=3 read
    do_reset();
    a_req = 1'b1; a_addr = 32'h0000_0300;
    mem_rdata = 32'h7777_7777;
    smp();
    chk("mid_c0_aack", 64'(l3_a_ack), 64'd1);
    nxt();
    a_req = 1'b0;
    nxt();
    rst = 1'b1;
    smp();
    chk("mid_c2_re", 64'(l3_mem_re), 64'd1);
    nxt();
    rst = 1'b0;
    smp();
    chk("mid_c3_outs", 64'({l3_mem_re, l3_mem_we, l3_a_ack, l3_b_ack, l3_a_done, l3_b_done}), 64'd0);
    chk("mid_c3_addr", 64'(l3_mem_addr), 64'd0);
    chk("mid_c3_rdata", 64'(l3_a_rdata), 64'd0);
    for (int c = 4; c < 9; c++) begin
      nxt();
      smp();
      chk($sformatf("mid_c%0d_done", c), 64'(l3_a_done), 64'd0);
    end
    nxt();
    a_req = 1'b1; b_req = 1'b1; b_addr = 32'h0000_0400;
    smp();
    chk("mid_tie_aack", 64'(l3_a_ack), 64'd1);
    chk("mid_tie_back", 64'(l3_b_ack), 64'd0);

    // idle stability
    do_reset();
    for (int c = 0; c < 20; c++) begin
      smp();
      chk($sformatf("idle_c%0d_l1", c),
          64'({l1_mem_re, l1_mem_we, l1_a_ack, l1_b_ack, l1_a_done, l1_b_done, l1_state}), 64'd0);
      chk($sformatf("idle_c%0d_l3", c),
          64'({l3_mem_re, l3_mem_we, l3_a_ack, l3_b_ack, l3_a_done, l3_b_done, l3_state}), 64'd0);
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_multi.md
Name: mem_arbiter_multi

Overview:
- Sequences and shares the single unified instruction/data memory port between two masters.
- Master A is the multicycle CPU datapath, for both fetch and load/store. Master B is a secondary master, such as the debug loader or DMA.
- Arbitrates with a two-way round-robin, latches the winning request, and drives the memory for LATENCY cycles.
- Returns read data with a one-cycle done pulse, so the CPU control FSM can stall its fetch/access states on it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 1, memory read latency in cycles; legal range 1..15.

Ports:
- iCLK  in  1  clock; all state changes on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iAReq  in  1  master A request; held until oAAck.
- iAWe  in  1  master A write (1) / read (0).
- iAAddr  in  ADDR_W  master A address.
- iAWData  in  DATA_W  master A write data.
- oAAck  out  1  master A request accepted (combinational, IDLE only).
- oADone  out  1  master A access complete (one-cycle pulse).
- oARData  out  DATA_W  master A read data, valid while oADone=1.
- iBReq, iBWe, iBAddr, iBWData, oBAck, oBDone, oBRData: same as the A ports, for master B.
- oMemAddr  out  ADDR_W  memory address.
- oMemWData  out  DATA_W  memory write data.
- oMemWe  out  1  memory write strobe.
- oMemRe  out  1  memory read enable.
- iMemRData  in  DATA_W  memory read data, valid LATENCY cycles after oMemRe first rises.

Behaviour:
- Reset (synchronous, iRST=1 at an edge):
  - state=IDLE, last-grant=B (so A wins the first tie), counter=0.
  - Address/data/we/owner registers cleared.
  - All outputs 0 in the following cycle. This includes oMemWe, oMemRe, both Ack, both Done, and both RData.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Only state in which requests are sampled.
  - Grant rules: only A requests -> A; only B -> B; both -> the master not in last-grant.
  - oXAck=1 combinationally for the granted master only.
  - At the edge: latch owner, Addr, WData, We; set last-grant=owner; counter=LATENCY; go to ACCESS.
  - No request: stay in IDLE; all strobes 0.
- ACCESS:
  - oMemAddr/oMemWData come from the latched registers.
  - Read: oMemRe=1 on every ACCESS cycle.
  - Write: oMemWe=1 only on the first ACCESS cycle.
  - Counter decrements each cycle.
  - When counter==1 at an edge: capture iMemRData into the owner's RData register (reads only), go to DONE.
  - So ACCESS lasts exactly LATENCY cycles.
- DONE:
  - oXDone=1 for the owner for exactly one cycle; oXRData holds the captured value (writes: RData unchanged).
  - Next state is IDLE, unconditionally.
- Timing:
  - Accept in cycle 0, Done in cycle LATENCY+1.
  - Back-to-back service costs LATENCY+2 cycles per access.
- Master rules:
  - A master drops Req, or presents a new request, on the cycle after Ack.
  - Req, Addr, WData and We must be stable while Req=1 and not yet acked.
  - Requests arriving during ACCESS/DONE are not lost; they wait, held, until the next IDLE.
- Fairness: with both masters continuously requesting, grants strictly alternate, so neither master waits more than one foreign access.
- Counter width is 4 bits; LATENCY=0 is illegal and is not supported.
- Reset mid-operation (iRST in ACCESS or DONE):
  - The access is abandoned; no Done is produced; memory strobes drop the next cycle.
  - A write already strobed stays written.
- Read data width is DATA_W with no sign or width processing; byte/half handling stays in the CPU datapath.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE (2 bits);
  - master IDs MST_A=0, MST_B=1;
  - the LATENCY range limit.
- Sub-module rr_arbiter_2:
  - inputs iCLK, iRST, iReqA, iReqB, iEn (IDLE); outputs oGntA, oGntB;
  - owns the last-grant register, updated only when iEn and a grant is issued.
- The top level holds the FSM, counter, latch registers and memory muxing.

Test Plan:
- Single read, LATENCY=1: A reads 0x00400000, memory returns 0xDEADBEEF -> oAAck in cycle 0; oMemRe in cycle 1; oADone=1 and oARData=0xDEADBEEF in cycle 2; IDLE in cycle 3.
- Tie after reset: A and B both request in the same cycle -> A acked first; B acked at the next IDLE (cycle 3); both held continuously -> acks alternate A, B, A, B.
- Write: B writes 0x12345678 to 0x10010000, LATENCY=3 -> oMemWe=1 for exactly one cycle (cycle 1) with that address/data; oBDone in cycle 4; oBRData unchanged.
- LATENCY=3 read: oMemRe held for cycles 1-3; data captured at the end of cycle 3; oADone in cycle 4; request B arriving in cycle 2 -> acked in cycle 5.
- Reset mid-access: iRST in cycle 2 of a LATENCY=3 read -> no oADone ever; all outputs 0 from cycle 3; a subsequent simultaneous A+B request grants A.
- Idle stability: no requests for 20 cycles -> oMemRe=oMemWe=0, no Ack or Done pulses, state remains IDLE.
